// File: rtl/debug_reg_read_agent.sv
`default_nettype none
// ============================================================================
// Module   : debug_reg_read_agent
// Brief    : Debug-host read agent for the sensitive register file, with
//            key-based unlock of the secure range and sticky bad-key lockout.
//            Optional idle auto-relock: define DBG_UNLOCK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debug_reg_read_agent #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] SECURE_BASE = 8'hF0,
    parameter logic [DATA_W-1:0] UNLOCK_KEY  = 32'hA5C30F1E,
    parameter int                MAX_FAIL    = 3,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_unlock,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_key,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              dbg_rsp_err,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              unlocked,
    output logic              locked_out
);

    localparam int               c_FCW       = $clog2(MAX_FAIL + 1);
    localparam logic [c_FCW-1:0] c_MAX_FAIL  = c_FCW'(MAX_FAIL);
    localparam logic [c_FCW-1:0] c_FAIL_LAST = c_FCW'(MAX_FAIL - 1);
    localparam logic [c_FCW-1:0] c_FAIL_ONE  = c_FCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_unlocked;
    logic              r_locked_out;
    logic [c_FCW-1:0]  r_fail_cnt;
    logic              w_accept;
    logic              w_denied;
    logic              w_timeout;

    assign w_accept = dbg_req_valid && dbg_req_ready;
    assign w_denied = (dbg_req_addr >= SECURE_BASE) && !r_unlocked;

`ifdef DBG_UNLOCK_TIMEOUT_EN
    localparam int                  c_IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_idle_tick;

    // Any non-idle state is only reachable through an accepted request,
    // so clearing whenever we are not ticking keeps the count consecutive.
    assign w_idle_tick = r_unlocked && (r_state == ST_IDLE) && !w_accept;
    assign w_timeout   = w_idle_tick && (r_idle_cnt == c_IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_idle_tick) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        dbg_req_ready = 1'b0;
        dbg_rsp_valid = 1'b0;
        rf_rd_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dbg_req_ready = !rst;
                if (w_accept) begin
                    w_state_nxt = (dbg_req_unlock || w_denied) ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                rf_rd_en    = 1'b1;
                w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                dbg_rsp_valid = 1'b1;
                if (dbg_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= dbg_req_addr;
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                        // Unlock priority: lockout, relock, good key, bad key
                        if (dbg_req_unlock) begin
                            if (r_locked_out) begin
                                r_rsp_err <= 1'b1;
                            end else if (dbg_req_key == '0) begin
                                r_unlocked <= 1'b0;
                            end else if (dbg_req_key == UNLOCK_KEY) begin
                                r_unlocked <= 1'b1;
                                r_fail_cnt <= '0;
                            end else begin
                                r_rsp_err  <= 1'b1;
                                r_unlocked <= 1'b0;
                                if (r_fail_cnt != c_MAX_FAIL) begin
                                    r_fail_cnt <= r_fail_cnt + c_FAIL_ONE;
                                end
                                if (r_fail_cnt == c_FAIL_LAST) begin
                                    r_locked_out <= 1'b1;
                                end
                            end
                        end else if (w_denied) begin
                            r_rsp_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_unlocked <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    r_rsp_data <= rf_rd_data;
                    r_rsp_err  <= 1'b0;
                end
                ST_RESP: begin
                    if (dbg_rsp_ready) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_rd_addr   = r_addr;
    assign dbg_rsp_data = r_rsp_data;
    assign dbg_rsp_err  = r_rsp_err;
    assign unlocked     = r_unlocked;
    assign locked_out   = r_locked_out;

endmodule
`default_nettype wire

// File: doc/debug_reg_read_agent.md
Name: debug_reg_read_agent

Overview:
- Debug-side read agent for the sensitive register file; it is the reader of the registers the file's write path updates.
- Accepts read and unlock requests from the debug host over a valid/ready channel and issues single-cycle reads to the register file.
- Returns data over a valid/ready response channel.
- Enforces access level: addresses at or above SECURE_BASE are readable only after a key unlock; repeated bad keys cause a lockout that holds until reset.

Parameters:
ADDR_W, 8, register file address width
DATA_W, 32, register data width
SECURE_BASE, 8'hF0, lowest protected address
UNLOCK_KEY, 32'hA5C30F1E, unlock key value
MAX_FAIL, 3, bad-key attempts before permanent lockout
TIMEOUT_CYC, 1024, idle cycles before auto-relock (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; sole clock domain
dbg_req_valid  in  1  request valid
dbg_req_ready  out  1  request ready
dbg_req_unlock  in  1  1 = unlock attempt, 0 = read
dbg_req_addr  in  ADDR_W  read address
dbg_req_key  in  DATA_W  unlock key (used only when unlock=1)
dbg_rsp_valid  out  1  response valid
dbg_rsp_ready  in  1  response ready
dbg_rsp_data  out  DATA_W  read data; 0 on error or unlock
dbg_rsp_err  out  1  access denied or bad key
rf_rd_en  out  1  register file read strobe
rf_rd_addr  out  ADDR_W  register file read address
rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en
unlocked  out  1  secure range accessible
locked_out  out  1  fail limit reached

Behaviour:
- Reset values: state=IDLE; all outputs 0; fail_cnt=0.
- Reset mid-transaction abandons it: no response is issued and the unlock state clears.
- dbg_req_ready = (state==IDLE) && !rst. A request is accepted on valid&&ready in cycle T.
- States: IDLE, READ, CAPT, RESP.
- Read, allowed (addr<SECURE_BASE or unlocked):
  - IDLE->READ.
  - T+1: rf_rd_en=1, rf_rd_addr=captured addr. Exactly one strobe per request.
  - T+2 (CAPT): rf_rd_data registered into dbg_rsp_data, err=0.
  - T+3 (RESP): dbg_rsp_valid=1.
- Read, denied (addr>=SECURE_BASE and !unlocked):
  - IDLE->RESP directly; no rf_rd_en.
  - dbg_rsp_valid=1 at T+1, data=0, err=1.
  - Does not change fail_cnt.
- Unlock attempt: IDLE->RESP; response at T+1, data=0. Priority:
  1. locked_out: err=1, no state change, even if the key is correct.
  2. key==0: relock; unlocked=0, err=0, fail_cnt unchanged.
  3. key==UNLOCK_KEY: unlocked=1, fail_cnt=0, err=0.
  4. Otherwise: err=1, unlocked=0, fail_cnt+1.
- Lockout: when fail_cnt reaches MAX_FAIL, locked_out=1 in the same update. It is sticky until rst.
- Unlock state changes take effect at the T+1 clock edge, so the next request sees the new state.
- RESP: dbg_rsp_valid, data and err hold stable until dbg_rsp_ready. The handshake cycle returns to IDLE with valid=0.
- Back-to-back: the next request can be accepted the cycle after the handshake. No pipelining; one outstanding request.
- dbg_req_* inputs are ignored outside IDLE.
- Boundaries:
  - addr=SECURE_BASE-1 is public; addr=SECURE_BASE is protected.
  - fail_cnt saturates at MAX_FAIL.
  - Only the captured address is used; the address input may change after acceptance.
  - rf_rd_data is sampled only in CAPT.

Optional Feature:
- Macro: DBG_UNLOCK_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles while unlocked=1 and state==IDLE with no accepted request.
  - It resets to 0 on any accepted request.
  - At TIMEOUT_CYC consecutive idle cycles, unlocked clears to 0 on the next edge.
  - fail_cnt is unaffected.
- Undefined: no counter; unlocked persists until relock or rst.

Test Plan:
- rf word 0x10=0x12345678; read 0x10 -> rf_rd_en exactly once at T+1 with addr 0x10; rsp_valid at T+3, data 0x12345678, err=0.
- Locked read of 0xF0 -> no rf_rd_en; rsp at T+1, data 0, err=1. Read 0xEF -> normal data returned.
- Unlock with 0xA5C30F1E, then read 0xF0 (rf=0xDEADBEEF) -> unlocked=1, data 0xDEADBEEF. Unlock with key 0, then read 0xF0 -> err=1.
- Three unlock attempts with key 0x1 -> err=1 each, locked_out=1 after the third. Then correct key -> err=1, unlocked stays 0. Assert rst -> locked_out=0, and the correct key then succeeds.
- Hold dbg_rsp_ready=0 for 5 cycles -> rsp stable, dbg_req_ready=0, new requests ignored. Assert rst during READ -> no response, unlocked=0.
- With DBG_UNLOCK_TIMEOUT_EN and TIMEOUT_CYC=16: unlock, idle 16 cycles -> unlocked=0. Same sequence with a read at idle cycle 10 -> still unlocked at cycle 20.
